ball_motion_ctrl: RTL and testbench
===================================

# ball_motion_ctrl

Per-frame ball kinematics sequencer for the quidditch game controller. On each frame tick it advances the ball by its direction vector and reflects it off the screen walls. It then tests for overlap with the player. On a hit it hands the current ball state to the combinational `ball_collider` and loads back the reflected position and direction. It sits directly upstream of `ball_collider`, driving its `old_ball_*` inputs and consuming its `new_ball_*` outputs.

## Interface
- `SCREEN_W`, 640, playfield width in pixels
- `SCREEN_H`, 480, playfield height in pixels
- `BALL_R`, 4, ball half-size
- `PLAYER_R`, 8, player half-size
- `HIT_COOLDOWN`, 8, frames after a hit during which further hits are ignored
- `MAX_SPEED`, 6, per-axis speed limit (used only with `BALL_SPEED_CLAMP_EN`)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `frame_tick`  in  1  one-cycle frame strobe
- `player_x`, `player_y`  in  10 each  player centre, unsigned
- `coll_ball_x`, `coll_ball_y`, `coll_dir_x`, `coll_dir_y`  in  11 each, signed  `ball_collider` outputs
- `ball_x`, `ball_y`  out  11 each, signed  ball centre; also feeds collider `old_ball_x/y`
- `dir_x`, `dir_y`  out  11 each, signed  velocity; also feeds collider `old_ball_dir_x/y`
- `busy`  out  1  high from the cycle after tick acceptance until `done`
- `done`  out  1  one-cycle pulse when the frame update completes
- `hit`  out  1  one-cycle pulse when collider results are loaded

## Operation
- Reset values:
  - `ball_x`=SCREEN_W/2 (320), `ball_y`=SCREEN_H/2 (240)
  - `dir_x`=2, `dir_y`=1
  - `busy`=`done`=`hit`=0; cooldown=0; state IDLE
- FSM states: IDLE, MOVE, WALL, CHECK, COLL_WAIT, COLL_LOAD, DONE.
- **IDLE:** `frame_tick`=1 → MOVE. Ticks arriving outside IDLE are dropped, not queued.
- **MOVE:** `ball += dir`, per axis, 11-bit signed wrap-free arithmetic.
- **WALL:** per axis, independently:
  - If `ball < BALL_R`: set `ball = BALL_R` and negate `dir`.
  - If `ball > SCREEN-1-BALL_R`: set `ball = SCREEN-1-BALL_R` and negate `dir`.
- **CHECK:** compute `dx = ball_x - player_x` and `dy = ball_y - player_y` (12-bit signed).
  - Hit when `|dx| <= BALL_R+PLAYER_R`, `|dy| <= BALL_R+PLAYER_R` and cooldown==0.
  - Hit → COLL_WAIT; otherwise → DONE.
- **COLL_WAIT:** one settle cycle for the combinational collider.
  - Exception: if `dx`==0 (collider would divide by zero), set `dir_y = -dir_y` here, leave position unchanged, and go straight to COLL_LOAD without sampling `coll_*`.
- **COLL_LOAD:**
  - Load `coll_*` into `ball_*`/`dir_*` (unless the `dx`==0 path was taken).
  - Clamp the loaded position to the wall limits above; direction is not negated by this clamp.
  - Set cooldown=HIT_COOLDOWN and pulse `hit`.
- **DONE:**
  - Pulse `done`.
  - Decrement cooldown if nonzero, except in a frame where it was just loaded.
  - Next state IDLE.
- `rst` asserted mid-update returns everything to reset values immediately. No partial update survives.

## Timing
- Tick sampled at edge 0:
  - `busy` rises after edge 0.
  - No hit: `done` is high in cycle 4.
  - Hit: `hit` is high in cycle 5 and `done` in cycle 6.
- `busy` falls together with `done` deasserting; next tick is accepted from cycle 5 (no hit) or cycle 7 (hit).
- `ball_*`/`dir_*` are registered. They are stable throughout COLL_WAIT, so collider inputs are constant for ≥1 full cycle before sampling.
- `hit` and `done` are never high in the same cycle.

## Configuration
- `BALL_SPEED_CLAMP_EN` defined: in COLL_LOAD, each loaded direction component is saturated to [-MAX_SPEED, +MAX_SPEED].
- Undefined: collider directions are loaded raw.
- Wall and `dx`==0 paths are unaffected in both cases.

## Structure
- Shared package `quidditch_pkg` holds:
  - `coord_t` (signed 11-bit)
  - the FSM state enum
  - constants SCREEN_W, SCREEN_H, BALL_R, PLAYER_R
- One sub-module, `ball_hit_detect`: combinational `dx`/`dy`, absolute value, box-overlap test and `dx_zero` flag.
- `ball_collider` is instantiated by the parent, not inside this block.

## Test plan
- **Reset, no hit:** player at (0,0), one tick → ball (322,241), dir (2,1), `done` in cycle 4, `hit`=0.
- **Right wall:** player (0,0), 158 ticks → `ball_x`=635 (clamped), `dir_x`=-2, `ball_y`=398.
- **Hit:**
  - Player (330,245), one tick: ball (322,241) → overlap detected.
  - Stub collider drives (300,250,-5,3) → ball (300,250), dir (-5,3), `hit` cycle 5, `done` cycle 6.
  - With `BALL_SPEED_CLAMP_EN` and stub dir (-20,3) → `dir_x`=-6.
- **Cooldown:** player moved to overlap the new ball position (300,250) on the next tick → no `hit`. Nine ticks later with overlap again → `hit` fires.
- **`dx`==0:** player (322,230), one tick → ball (322,241), dir (2,-1), `coll_*` ignored, `hit` pulses.
- **Busy / reset:**
  - `frame_tick` held high for 20 cycles → exactly 4 updates.
  - `rst` pulsed in cycle 2 of an update → ball (320,240), dir (2,1), `busy`=0.

Source files
------------

// File: rtl/quidditch_pkg.sv
// Shared types and constants for the quidditch ball logic: coordinate type,
// ball sequencer state encoding, playfield geometry and wall/speed helpers.
package quidditch_pkg;

  typedef logic signed [10:0] coord_t;

  typedef enum logic [2:0] {
    IDLE,
    MOVE,
    WALL,
    CHECK,
    COLL_WAIT,
    COLL_LOAD,
    DONE
  } state_t;

  localparam int SCREEN_W     = 640;
  localparam int SCREEN_H     = 480;
  localparam int BALL_R       = 4;
  localparam int PLAYER_R     = 8;
  localparam int HIT_COOLDOWN = 8;
  localparam int MAX_SPEED    = 6;

  // Legal range of the ball centre on each axis.
  localparam coord_t EDGE_MIN = coord_t'(BALL_R);
  localparam coord_t X_MAX    = coord_t'(SCREEN_W - 1 - BALL_R);
  localparam coord_t Y_MAX    = coord_t'(SCREEN_H - 1 - BALL_R);

  localparam coord_t SPEED_MAX = coord_t'(MAX_SPEED);
  localparam coord_t SPEED_MIN = coord_t'(-MAX_SPEED);

  // Pull a coordinate back inside [EDGE_MIN, hi].
  function automatic coord_t wall_clamp(coord_t v, coord_t hi);
    if (v < EDGE_MIN) return EDGE_MIN;
    else if (v > hi) return hi;
    return v;
  endfunction

  // Saturate one velocity component to the per-axis speed limit.
  function automatic coord_t speed_sat(coord_t v);
    if (v > SPEED_MAX) return SPEED_MAX;
    else if (v < SPEED_MIN) return SPEED_MIN;
    return v;
  endfunction

endpackage

// File: rtl/ball_hit_detect.sv
// Ball/player box-overlap test. Purely combinational: signed distances on a
// 12-bit grid, absolute values, overlap flag and the dx==0 flag that steers
// the sequencer away from the collider's divide.
module ball_hit_detect
  import quidditch_pkg::*;
(
  input  logic signed [10:0] ball_x,
  input  logic signed [10:0] ball_y,
  input  logic [9:0]         player_x,
  input  logic [9:0]         player_y,
  output logic               overlap,
  output logic               dx_zero
);

  localparam logic signed [11:0] HIT_DIST = 12'(BALL_R + PLAYER_R);

  logic signed [11:0] dx, dy, adx, ady;

  // Distances, magnitudes and the overlap decision.
  always_comb begin
    dx      = $signed({ball_x[10], ball_x}) - $signed({2'b00, player_x});
    dy      = $signed({ball_y[10], ball_y}) - $signed({2'b00, player_y});
    adx     = dx[11] ? -dx : dx;
    ady     = dy[11] ? -dy : dy;
    overlap = (adx <= HIT_DIST) && (ady <= HIT_DIST);
    dx_zero = (dx == 12'sd0);
  end

endmodule

// File: rtl/ball_motion_ctrl.sv
// Per-frame ball kinematics sequencer: move, wall bounce, player hit test,
// then hand-off to the external ball_collider and reload of its results.
// Optional build macro BALL_SPEED_CLAMP_EN saturates collider directions
// to +/-MAX_SPEED when they are loaded.
module ball_motion_ctrl
  import quidditch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic [9:0]         player_x,
  input  logic [9:0]         player_y,
  input  logic signed [10:0] coll_ball_x,
  input  logic signed [10:0] coll_ball_y,
  input  logic signed [10:0] coll_dir_x,
  input  logic signed [10:0] coll_dir_y,
  output logic signed [10:0] ball_x,
  output logic signed [10:0] ball_y,
  output logic signed [10:0] dir_x,
  output logic signed [10:0] dir_y,
  output logic               busy,
  output logic               done,
  output logic               hit
);

  state_t     state, next_state;
  logic [3:0] cooldown;
  logic       cd_fresh;   // cooldown was loaded during the current frame
  logic       zero_path;  // dx==0 hit: bounce locally, ignore the collider
  logic       overlap, dx_zero;
  coord_t     load_dir_x, load_dir_y;

  ball_hit_detect u_hit_detect (
    .ball_x   (ball_x),
    .ball_y   (ball_y),
    .player_x (player_x),
    .player_y (player_y),
    .overlap  (overlap),
    .dx_zero  (dx_zero)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state and Moore outputs; ticks outside IDLE are simply dropped.
  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    next_state = state;
    busy       = (state != IDLE);
    done       = 1'b0;
    hit        = 1'b0;
    case (state)
      IDLE:      if (frame_tick) next_state = MOVE;
      MOVE:      next_state = WALL;
      WALL:      next_state = CHECK;
      CHECK:     next_state = (overlap && cooldown == 4'd0) ? COLL_WAIT : DONE;
      COLL_WAIT: next_state = COLL_LOAD;
      COLL_LOAD: begin
        hit        = 1'b1;
        next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default:   next_state = IDLE;
    endcase
  end

  // Direction values taken from the collider, optionally speed-limited.
  always_comb begin
`ifdef BALL_SPEED_CLAMP_EN
    load_dir_x = speed_sat(coll_dir_x);
    load_dir_y = speed_sat(coll_dir_y);
`else
    load_dir_x = coll_dir_x;
    load_dir_y = coll_dir_y;
`endif
  end

  // Ball position/velocity and hit-cooldown datapath, stepped by the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ball_x    <= coord_t'(SCREEN_W / 2);
      ball_y    <= coord_t'(SCREEN_H / 2);
      dir_x     <= coord_t'(2);
      dir_y     <= coord_t'(1);
      cooldown  <= 4'd0;
      cd_fresh  <= 1'b0;
      zero_path <= 1'b0;
    end else begin
      case (state)
        MOVE: begin
          ball_x <= ball_x + dir_x;
          ball_y <= ball_y + dir_y;
        end
        WALL: begin
          ball_x <= wall_clamp(ball_x, X_MAX);
          ball_y <= wall_clamp(ball_y, Y_MAX);
          if (wall_clamp(ball_x, X_MAX) != ball_x) dir_x <= -dir_x;
          if (wall_clamp(ball_y, Y_MAX) != ball_y) dir_y <= -dir_y;
        end
        CHECK: zero_path <= dx_zero;
        COLL_WAIT: if (zero_path) dir_y <= -dir_y;
        COLL_LOAD: begin
          if (!zero_path) begin
            ball_x <= wall_clamp(coll_ball_x, X_MAX);
            ball_y <= wall_clamp(coll_ball_y, Y_MAX);
            dir_x  <= load_dir_x;
            dir_y  <= load_dir_y;
          end
          cooldown <= 4'(HIT_COOLDOWN);
          cd_fresh <= 1'b1;
        end
        DONE: begin
          if (cooldown != 4'd0 && !cd_fresh) cooldown <= cooldown - 4'd1;
          cd_fresh <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Self-checking bench for ball_motion_ctrl. A frame-level integer model of
// the ball rules predicts every frame; a negedge process compares the
// handshake outputs each cycle and the ball state at done. A stub collider
// is driven directly by the stimulus.
module tb_ball_motion_ctrl;

  logic               clk = 1'b0;
  logic               rst;
  logic               frame_tick;
  logic [9:0]         player_x, player_y;
  logic signed [10:0] coll_ball_x, coll_ball_y, coll_dir_x, coll_dir_y;
  logic signed [10:0] ball_x, ball_y, dir_x, dir_y;
  logic               busy, done, hit;

  ball_motion_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .player_x    (player_x),
    .player_y    (player_y),
    .coll_ball_x (coll_ball_x),
    .coll_ball_y (coll_ball_y),
    .coll_dir_x  (coll_dir_x),
    .coll_dir_y  (coll_dir_y),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .dir_x       (dir_x),
    .dir_y       (dir_y),
    .busy        (busy),
    .done        (done),
    .hit         (hit)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- frame-level model ----------------
  int mbx, mby, mdx, mdy, mcd;
  bit m_hit;

  task automatic model_reset();
    mbx = 320; mby = 240; mdx = 2; mdy = 1; mcd = 0;
  endtask

  function automatic int lim(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int speed(input int v);
`ifdef BALL_SPEED_CLAMP_EN
    return lim(v, -6, 6);
`else
    return v;
`endif
  endfunction

  task automatic model_frame(input int px, input int py);
    int bx, by, ddx, ddy;
    bx = mbx + mdx;
    by = mby + mdy;
    if (bx < 4 || bx > 635) begin bx = lim(bx, 4, 635); mdx = -mdx; end
    if (by < 4 || by > 475) begin by = lim(by, 4, 475); mdy = -mdy; end
    ddx = bx - px;
    ddy = by - py;
    m_hit = (ddx >= -12 && ddx <= 12 && ddy >= -12 && ddy <= 12 && mcd == 0);
    if (m_hit) begin
      if (ddx == 0) mdy = -mdy;
      else begin
        bx  = lim(int'(coll_ball_x), 4, 635);
        by  = lim(int'(coll_ball_y), 4, 475);
        mdx = speed(int'(coll_dir_x));
        mdy = speed(int'(coll_dir_y));
      end
      mcd = 8;
    end else if (mcd > 0) mcd--;
    mbx = bx;
    mby = by;
  endtask

  // ---------------- per-cycle compare ----------------
  int cyc          = 0;
  int start_cyc    = -1000000;
  int exp_last     = 4;
  bit exp_hit      = 1'b0;
  int last_hit_cyc = -1000000;
  int done_cnt     = 0;
  bit mon_en       = 1'b0;

  always @(negedge clk) begin
    int fc;
    cyc++;
    if (done) done_cnt++;
    if (hit) last_hit_cyc = cyc;
    fc = cyc - start_cyc;
    if (mon_en && !rst) begin
      if (fc >= 1 && fc <= exp_last + 1) begin
        check("busy", int'(busy), int'(fc <= exp_last));
        check("done", int'(done), int'(fc == exp_last));
        check("hit", int'(hit), int'(exp_hit && fc == 5));
        if (hit && done) check("hit_done_overlap", 1, 0);
        if (fc == exp_last) begin
          check("ball_x", int'(ball_x), mbx);
          check("ball_y", int'(ball_y), mby);
          check("dir_x", int'(dir_x), mdx);
          check("dir_y", int'(dir_y), mdy);
        end
      end else begin
        check("idle_busy", int'(busy), 0);
        check("idle_done", int'(done), 0);
        check("idle_hit", int'(hit), 0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_frame(input int px, input int py, output bit saw_hit);
    @(posedge clk); #1;
    start_cyc = -1000000;
    player_x  = 10'(px);
    player_y  = 10'(py);
    model_frame(px, py);
    exp_hit   = m_hit;
    exp_last  = m_hit ? 6 : 4;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    start_cyc  = cyc;
    for (int i = 0; i < 20 && (cyc - start_cyc) <= exp_last; i++) @(posedge clk);
    check("frame_timeout", int'((cyc - start_cyc) > exp_last), 1);
    saw_hit = (last_hit_cyc > start_cyc);
    if (exp_hit) check("hit_cycle", last_hit_cyc - start_cyc, 5);
    start_cyc = -1000000;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic check_ball(input string tag, input int bx, input int by,
                            input int dx, input int dy);
    check({tag, "_ball_x"}, int'(ball_x), bx);
    check({tag, "_ball_y"}, int'(ball_y), by);
    check({tag, "_dir_x"}, int'(dir_x), dx);
    check({tag, "_dir_y"}, int'(dir_y), dy);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit h;
    int d0;
    rst = 1'b1; frame_tick = 1'b0;
    player_x = '0; player_y = '0;
    coll_ball_x = '0; coll_ball_y = '0; coll_dir_x = '0; coll_dir_y = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check_ball("reset", 320, 240, 2, 1);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_hit", int'(hit), 0);
    mon_en = 1'b1;

    // One plain frame.
    do_frame(0, 0, h);
    check_ball("frame1", 322, 241, 2, 1);
    check("frame1_nohit", int'(h), 0);

    // Run into the right wall: 158 frames from reset.
    for (int i = 0; i < 157; i++) do_frame(0, 0, h);
    check_ball("right_wall", 635, 398, -2, 1);

    // Collider hit.
    do_reset();
    coll_ball_x = 11'sd300; coll_ball_y = 11'sd250;
    coll_dir_x  = -11'sd5;  coll_dir_y  = 11'sd3;
    do_frame(330, 245, h);
    check("hit_seen", int'(h), 1);
    check_ball("hit", 300, 250, -5, 3);

    // Cooldown: player sits next to the ball's next position every frame.
    coll_dir_x = -11'sd20;
    for (int k = 2; k <= 10; k++) begin
      do_frame(mbx + mdx + 3, mby + mdy + 2, h);
      if (k == 2) check("cooldown_f2_blocked", int'(h), 0);
      if (k == 9) check("cooldown_f9_blocked", int'(h), 0);
      if (k == 10) check("cooldown_f10_hit", int'(h), 1);
    end
`ifdef BALL_SPEED_CLAMP_EN
    check_ball("rehit", 300, 250, -6, 3);
`else
    check_ball("rehit", 300, 250, -20, 3);
`endif

    // dx == 0: local vertical bounce, collider ignored.
    do_reset();
    coll_ball_x = 11'sd100; coll_ball_y = 11'sd100;
    coll_dir_x  = 11'sd7;   coll_dir_y  = 11'sd7;
    do_frame(322, 230, h);
    check("dx0_hit", int'(h), 1);
    check_ball("dx0", 322, 241, 2, -1);

    // Tick held high for 20 cycles while busy: only 4 updates taken.
    do_reset();
    mon_en   = 1'b0;
    player_x = '0; player_y = '0;
    d0 = done_cnt;
    @(posedge clk); #1 frame_tick = 1'b1;
    repeat (20) @(posedge clk);
    #1 frame_tick = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("held_tick_updates", done_cnt - d0, 4);
    for (int i = 0; i < 4; i++) model_frame(0, 0);
    check_ball("held_tick", 328, 244, 2, 1);
    check_ball("held_tick_model", mbx, mby, mdx, mdy);

    // Reset in cycle 2 of an update.
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    #1;
    check_ball("mid_reset", 320, 240, 2, 1);
    check("mid_reset_busy", int'(busy), 0);
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("after_reset_busy", int'(busy), 0);
    check_ball("after_reset", 320, 240, 2, 1);
    mon_en = 1'b1;
    do_frame(0, 0, h);
    check_ball("post_reset_frame", 322, 241, 2, 1);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
